clk_div_ctrl: RTL and testbench
===============================

# clk_div_ctrl

Run-time ratio controller for the system clock divider. Two requesters (register file and UART prescale logic) ask for a new divide ratio. The block arbitrates between them and applies the change glitch-free: it parks the divider with its output low, loads the new ratio, re-enables it, then confirms lock on the first divided-clock rising edge. It sits in the reference-clock domain, between the configuration logic and the divider's `i_clk_en`/`i_div_ratio` inputs.

## Interface
- `RATIO_W`, 3: divide-ratio width.
- `DEF_RATIO`, 3'd2: ratio driven out of reset.
- `SETTLE_CYC`, 4: cycles the divider is held disabled after the new ratio is loaded.
- `TMO_CYC`, 16: maximum cycles to wait for the lock edge.
- `i_clk`  in  1  reference clock; same clock as the divider.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_req`  in  2  change requests; bit 0 = register file, bit 1 = UART prescale. Level, held until granted.
- `i_ratio0`  in  RATIO_W  ratio requested by requester 0.
- `i_ratio1`  in  RATIO_W  ratio requested by requester 1.
- `i_div_clk`  in  1  divider output fed back (already registered on `i_clk`; no synchronizer).
- `o_gnt`  out  2  one-cycle grant pulse, one-hot.
- `o_busy`  out  1  high while a change is in progress.
- `o_done`  out  1  one-cycle pulse: new ratio active.
- `o_err`  out  1  one-cycle pulse: illegal ratio, or lock timeout.
- `o_div_ratio`  out  RATIO_W  drives divider `i_div_ratio`.
- `o_clk_en`  out  1  drives divider `i_clk_en`.

## Operation
- **Reset values:** `o_div_ratio`=DEF_RATIO, `o_clk_en`=1, `o_gnt`=0, `o_busy`=0, `o_done`=0, `o_err`=0. State=IDLE, round-robin pointer=0.
- **Arbitration (IDLE only):**
  - Round-robin between the two requesters.
  - If both request, the requester the pointer selects wins; the pointer then moves to the other requester.
  - A single request always wins.
- **Grant:** the winning ratio is captured into `new_ratio` in the arbitration cycle.
- **IDLE → DRAIN** on grant of a legal, different ratio.
- **Same-ratio request:** `o_gnt` and `o_done` pulse together; no disruption to the divider; state stays IDLE.
- **Ratio 0 (illegal):** `o_gnt` and `o_err` pulse together; no change; state stays IDLE.
- **Ratio 1:** legal (divider bypass, output not toggling).
- **DRAIN:** `o_clk_en` stays 1 until `i_div_clk` samples 0. In that cycle, drive `o_clk_en`=0, load `o_div_ratio`=`new_ratio`, and go to HOLD.
- **HOLD:** count SETTLE_CYC cycles with `o_clk_en`=0, then set `o_clk_en`=1 and go to LOCK.
- **LOCK:**
  - Detect a rising edge as `i_div_clk` & ~`div_clk_q`.
  - On an edge, pulse `o_done` → IDLE.
  - If `new_ratio`==1, go IDLE immediately with `o_done`.
  - If TMO_CYC cycles pass without an edge, pulse `o_err` → IDLE. `o_div_ratio` stays at the new value.
- **Busy:** `o_busy`=1 in DRAIN/HOLD/LOCK. Requests are ignored (not granted) while busy.
- **Reset mid-change:** return to the reset values on the next edge; any in-flight request is dropped, not granted.

## Timing
- Request seen at cycle t in IDLE → `o_gnt` at t+1 (registered). For a legal, different ratio, `o_busy` is also high from t+1.
- DRAIN exit: at most ceil(ratio/2)+1 cycles when the old output is high; the same cycle when it is already low.
- `o_div_ratio` changes exactly once per transaction, only while `o_clk_en`=0.
- `o_clk_en` is low for exactly SETTLE_CYC+1 cycles.
- Total latency, grant to `o_done`: DRAIN + SETTLE_CYC + 1 + up to half the new period.
- `o_done` and `o_err` are never high together.
- A requester whose `i_req` falls before its grant is not granted.

## Structure
- **Package `clk_div_ctrl_pkg`:**
  - State enum: IDLE, DRAIN, HOLD, LOCK.
  - Default localparams for SETTLE_CYC, TMO_CYC, DEF_RATIO.
- **Sub-module `clk_div_rr_arb`:** 2-way round-robin arbiter (request vector in, one-hot grant out, pointer update on accept).
- **Top level:** FSM, settle/timeout counter (shared, $clog2(max)+1 bits), edge-detect register.

## Test plan
- **Reset:** hold `i_rst` 3 cycles → `o_div_ratio`=2, `o_clk_en`=1, all pulses 0.
- **Basic change:** `i_req`=01, `i_ratio0`=4 → `o_gnt`=01 one cycle later; `o_clk_en` low 5 cycles while `i_div_clk` is low; `o_div_ratio`=4; `o_done` after the first rising edge; the divided period measures 4 cycles.
- **Contention:** `i_req`=11 with ratios 3/5 → grant 01 first (pointer 0); requester 1 stays held and is granted after `o_done`; final ratio 5; a third simultaneous request is granted to 01 again.
- **Illegal/same ratio:** request ratio 0 → `o_gnt`+`o_err` same cycle, ratio unchanged. Request ratio equal to current → `o_gnt`+`o_done`, `o_clk_en` never drops.
- **Timeout:** tie `i_div_clk`=0 in LOCK with ratio 6 → `o_err` after 16 cycles, `o_busy` falls.
- **Reset mid-HOLD:** assert `i_rst` → next cycle ratio=2, `o_clk_en`=1, state IDLE, no `o_done`.

Source files
------------

// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and default parameters for the run-time clock-divider ratio controller.
package clk_div_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HOLD  = 2'd2,
      ST_LOCK  = 2'd3
   } state_e;

   localparam int unsigned DEF_RATIO_W    = 3;
   localparam int unsigned DEF_SETTLE_CYC = 4;
   localparam int unsigned DEF_TMO_CYC    = 16;
   localparam logic [2:0]  DEF_DIV_RATIO  = 3'd2;

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/clk_div_rr_arb.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer moves past the winner on accept.
module clk_div_rr_arb (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [1:0] i_req,
   input  logic       i_accept,
   output logic [1:0] o_gnt
);

   logic ptr_q;
   logic ptr_d;

   // Grant selection; the pointer only matters when both requesters contend.
   always_comb begin
      o_gnt = 2'b00;
      case (i_req)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         2'b11:   o_gnt = ptr_q ? 2'b10 : 2'b01;
         default: o_gnt = 2'b00;
      endcase
   end

   // After any accepted grant the pointer favours the requester that lost.
   always_comb begin
      ptr_d = ptr_q;
      if (i_accept && (o_gnt != 2'b00)) begin
         ptr_d = o_gnt[0];
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Pointer register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/clk_div_ctrl.sv
// Arbitrates divide-ratio change requests and sequences the divider through a glitch-free
// park / load / settle / lock handshake.
module clk_div_ctrl
   import clk_div_ctrl_pkg::*;
#(
   parameter int unsigned               RATIO_W    = DEF_RATIO_W,
   parameter logic [RATIO_W-1:0]        DEF_RATIO  = RATIO_W'(DEF_DIV_RATIO),
   parameter int unsigned               SETTLE_CYC = DEF_SETTLE_CYC,
   parameter int unsigned               TMO_CYC    = DEF_TMO_CYC
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [1:0]         i_req,
   input  logic [RATIO_W-1:0] i_ratio0,
   input  logic [RATIO_W-1:0] i_ratio1,
   input  logic               i_div_clk,
   output logic [1:0]         o_gnt,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_err,
   output logic [RATIO_W-1:0] o_div_ratio,
   output logic               o_clk_en
);

   localparam int unsigned CNT_W = $clog2(max2(SETTLE_CYC, TMO_CYC)) + 1;

   state_e             state_q,     state_d;
   logic [RATIO_W-1:0] new_ratio_q, new_ratio_d;
   logic [RATIO_W-1:0] div_ratio_q, div_ratio_d;
   logic [CNT_W-1:0]   cnt_q,       cnt_d;
   logic [1:0]         gnt_q,       gnt_d;
   logic               clk_en_q,    clk_en_d;
   logic               busy_q,      busy_d;
   logic               done_q,      done_d;
   logic               err_q,       err_d;
   logic               div_clk_q;

   logic               arb_en;
   logic [1:0]         arb_req;
   logic [1:0]         arb_gnt;
   logic [RATIO_W-1:0] win_ratio;
   logic               div_rise;

   // The grant-pulse cycle is excluded so a requester still holding its level is not granted twice.
   assign arb_en    = (state_q == ST_IDLE) && (gnt_q == 2'b00);
   assign arb_req   = arb_en ? i_req : 2'b00;
   assign win_ratio = arb_gnt[1] ? i_ratio1 : i_ratio0;
   assign div_rise  = i_div_clk & ~div_clk_q;

   clk_div_rr_arb u_arb (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_req    (arb_req),
      .i_accept (arb_en),
      .o_gnt    (arb_gnt)
   );

   // Next-state and output decode for the change sequence.
   always_comb begin
      state_d     = state_q;
      new_ratio_d = new_ratio_q;
      div_ratio_d = div_ratio_q;
      clk_en_d    = clk_en_q;
      cnt_d       = cnt_q;
      gnt_d       = 2'b00;
      done_d      = 1'b0;
      err_d       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (arb_gnt != 2'b00) begin
               gnt_d       = arb_gnt;
               new_ratio_d = win_ratio;
               if (win_ratio == {RATIO_W{1'b0}}) begin
                  err_d = 1'b1;
               end else if (win_ratio == div_ratio_q) begin
                  done_d = 1'b1;
               end else begin
                  state_d = ST_DRAIN;
               end
            end else begin
               gnt_d = 2'b00;
            end
         end
         ST_DRAIN: begin
            if (!i_div_clk) begin
               clk_en_d    = 1'b0;
               div_ratio_d = new_ratio_q;
               cnt_d       = {CNT_W{1'b0}};
               state_d     = ST_HOLD;
            end else begin
               clk_en_d = 1'b1;
            end
         end
         ST_HOLD: begin
            if (cnt_q == CNT_W'(SETTLE_CYC)) begin
               clk_en_d = 1'b1;
               cnt_d    = {CNT_W{1'b0}};
               state_d  = ST_LOCK;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_LOCK: begin
            // Ratio 1 bypasses the divider, so no edge will ever arrive.
            if (div_rise || (new_ratio_q == RATIO_W'(1))) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_W'(TMO_CYC - 1)) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State, counter and registered-output update.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         new_ratio_q <= DEF_RATIO;
         div_ratio_q <= DEF_RATIO;
         clk_en_q    <= 1'b1;
         cnt_q       <= {CNT_W{1'b0}};
         gnt_q       <= 2'b00;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         div_clk_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         new_ratio_q <= new_ratio_d;
         div_ratio_q <= div_ratio_d;
         clk_en_q    <= clk_en_d;
         cnt_q       <= cnt_d;
         gnt_q       <= gnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         div_clk_q   <= i_div_clk;
      end
   end

   assign o_gnt       = gnt_q;
   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_err       = err_q;
   assign o_div_ratio = div_ratio_q;
   assign o_clk_en    = clk_en_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl with a behavioural divider model closing the i_div_clk loop.
module tb_clk_div_ctrl;

   typedef struct packed {
      logic       done;
      logic       err;
      logic [2:0] ratio;
   } cmp_t;

   logic       clk;
   logic       i_rst;
   logic [1:0] req;
   logic [2:0] ratio0;
   logic [2:0] ratio1;
   logic       div_clk;
   logic [1:0] o_gnt;
   logic       o_busy;
   logic       o_done;
   logic       o_err;
   logic [2:0] o_div_ratio;
   logic       o_clk_en;

   int   errors = 0;
   int   checks = 0;
   int   en_low_total = 0;
   logic mon_en = 1'b0;
   logic len_chk = 1'b1;
   logic tie_low = 1'b0;
   logic [2:0] mdl_cnt = 3'd0;

   logic [1:0] gnt_exp_q[$];
   cmp_t       cmp_exp_q[$];

   clk_div_ctrl dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_req       (req),
      .i_ratio0    (ratio0),
      .i_ratio1    (ratio1),
      .i_div_clk   (div_clk),
      .o_gnt       (o_gnt),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_err       (o_err),
      .o_div_ratio (o_div_ratio),
      .o_clk_en    (o_clk_en)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Divider model: parked low while disabled, ratio<=1 is a non-toggling bypass, else period = ratio.
   always @(posedge clk) begin
      if (i_rst || !o_clk_en) begin
         mdl_cnt <= 3'd0;
         div_clk <= 1'b0;
      end else if (o_div_ratio <= 3'd1) begin
         mdl_cnt <= 3'd0;
         div_clk <= 1'b0;
      end else begin
         mdl_cnt <= (mdl_cnt == o_div_ratio - 3'd1) ? 3'd0 : mdl_cnt + 3'd1;
         div_clk <= tie_low ? 1'b0 : ({1'b0, mdl_cnt} < (({1'b0, o_div_ratio} + 4'd1) >> 1));
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int idx, input logic [2:0] r);
      if (idx == 0) begin
         ratio0 = r;
         req[0] = 1'b1;
      end else begin
         ratio1 = r;
         req[1] = 1'b1;
      end
   endtask

   task automatic wait_quiet(input string name);
      int n;
      n = 0;
      while ((req != 2'b00 || o_busy || gnt_exp_q.size() != 0 || cmp_exp_q.size() != 0) && n < 400) begin
         tick();
         n++;
      end
      chk({name, "_completes"}, (n < 400), 1);
   endtask

   task automatic wait_en(input logic lvl, input string name);
      int n;
      n = 0;
      while (o_clk_en !== lvl && n < 100) begin
         tick();
         n++;
      end
      chk(name, (n < 100), 1);
   endtask

   task automatic measure_period(input int exp_per);
      int   cyc;
      int   t1;
      int   per;
      logic p;
      cyc = 0;
      t1  = -1;
      per = -1;
      p   = div_clk;
      while (per < 0 && cyc < 100) begin
         tick();
         cyc++;
         if (div_clk && !p) begin
            if (t1 < 0) t1 = cyc;
            else per = cyc - t1;
         end
         p = div_clk;
      end
      chk("div_period", per, exp_per);
   endtask

   // Requesters hold their level until they see their own grant.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (o_gnt[0] === 1'b1) req[0] = 1'b0;
         if (o_gnt[1] === 1'b1) req[1] = 1'b0;
      end
   end

   // Monitor: pops expectations on grant / completion pulses and watches clk_en / ratio rules.
   initial begin
      int         low_run;
      logic [2:0] prev_ratio;
      logic       rst_prev;
      logic [1:0] eg;
      cmp_t       ec;
      low_run    = 0;
      prev_ratio = 3'd2;
      rst_prev   = 1'b1;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            chk("done_err_overlap", (o_done & o_err), 0);
            if (o_gnt != 2'b00) begin
               if (gnt_exp_q.size() == 0) begin
                  chk("unexpected_gnt", o_gnt, 0);
               end else begin
                  eg = gnt_exp_q.pop_front();
                  chk("gnt", o_gnt, eg);
               end
            end
            if (o_done || o_err) begin
               if (cmp_exp_q.size() == 0) begin
                  chk("unexpected_done_err", {o_done, o_err}, 0);
               end else begin
                  ec = cmp_exp_q.pop_front();
                  chk("done", o_done, ec.done);
                  chk("err", o_err, ec.err);
                  chk("ratio_at_completion", o_div_ratio, ec.ratio);
               end
            end
            if (!o_clk_en) begin
               low_run++;
               en_low_total++;
            end else if (low_run != 0) begin
               if (len_chk) chk("clk_en_low_len", low_run, 5);
               low_run = 0;
            end
            if (o_div_ratio != prev_ratio && !rst_prev) chk("ratio_change_while_enabled", o_clk_en, 0);
         end
         prev_ratio = o_div_ratio;
         rst_prev   = i_rst;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int low0;
      i_rst  = 1'b1;
      req    = 2'b00;
      ratio0 = 3'd0;
      ratio1 = 3'd0;
      repeat (3) tick();
      i_rst = 1'b0;
      chk("rst_ratio", o_div_ratio, 2);
      chk("rst_clk_en", o_clk_en, 1);
      chk("rst_gnt", o_gnt, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_err", o_err, 0);
      mon_en = 1'b1;

      // Contention 3/5: pointer 0 favours requester 0, requester 1 follows after done.
      gnt_exp_q.push_back(2'b01);
      gnt_exp_q.push_back(2'b10);
      cmp_exp_q.push_back('{done: 1'b1, err: 1'b0, ratio: 3'd3});
      cmp_exp_q.push_back('{done: 1'b1, err: 1'b0, ratio: 3'd5});
      ratio0 = 3'd3;
      ratio1 = 3'd5;
      req    = 2'b11;
      tick();
      chk("busy_with_first_grant", o_busy, 1);
      wait_quiet("contention");
      chk("contention_final_ratio", o_div_ratio, 5);

      // Third simultaneous request: requester 0 first again, then a same-ratio request from 1.
      gnt_exp_q.push_back(2'b01);
      gnt_exp_q.push_back(2'b10);
      cmp_exp_q.push_back('{done: 1'b1, err: 1'b0, ratio: 3'd4});
      cmp_exp_q.push_back('{done: 1'b1, err: 1'b0, ratio: 3'd4});
      ratio0 = 3'd4;
      ratio1 = 3'd4;
      req    = 2'b11;
      wait_quiet("third_contention");
      measure_period(4);

      // Illegal ratio 0.
      gnt_exp_q.push_back(2'b01);
      cmp_exp_q.push_back('{done: 1'b0, err: 1'b1, ratio: 3'd4});
      issue(0, 3'd0);
      wait_quiet("illegal");
      chk("illegal_ratio_kept", o_div_ratio, 4);

      // Same ratio: no disruption to the divider enable.
      low0 = en_low_total;
      gnt_exp_q.push_back(2'b10);
      cmp_exp_q.push_back('{done: 1'b1, err: 1'b0, ratio: 3'd4});
      issue(1, 3'd4);
      wait_quiet("same_ratio");
      chk("same_ratio_no_en_drop", en_low_total - low0, 0);

      // Ratio 1 completes without a lock edge.
      gnt_exp_q.push_back(2'b01);
      cmp_exp_q.push_back('{done: 1'b1, err: 1'b0, ratio: 3'd1});
      issue(0, 3'd1);
      wait_quiet("ratio1");

      // Lock timeout with the divider output stuck low.
      tie_low = 1'b1;
      gnt_exp_q.push_back(2'b10);
      cmp_exp_q.push_back('{done: 1'b0, err: 1'b1, ratio: 3'd6});
      issue(1, 3'd6);
      wait_en(1'b0, "tmo_reach_hold");
      wait_en(1'b1, "tmo_reach_lock");
      n = 0;
      while (!o_err && n < 40) begin
         tick();
         n++;
      end
      chk("tmo_cycles", n, 16);
      chk("tmo_busy_falls", o_busy, 0);
      tie_low = 1'b0;
      wait_quiet("timeout");

      // Reset in the middle of HOLD drops the change.
      len_chk = 1'b0;
      gnt_exp_q.push_back(2'b01);
      issue(0, 3'd3);
      wait_en(1'b0, "rst_reach_hold");
      tick();
      tick();
      chk("rst_mid_hold_in_hold", o_clk_en, 0);
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      chk("rst_mid_ratio", o_div_ratio, 2);
      chk("rst_mid_clk_en", o_clk_en, 1);
      chk("rst_mid_busy", o_busy, 0);
      chk("rst_mid_done", o_done, 0);
      repeat (30) tick();
      chk("rst_mid_idle_busy", o_busy, 0);
      chk("rst_mid_gnt_consumed", gnt_exp_q.size(), 0);
      len_chk = 1'b1;

      // Change after reset, measured divided period.
      gnt_exp_q.push_back(2'b10);
      cmp_exp_q.push_back('{done: 1'b1, err: 1'b0, ratio: 3'd5});
      issue(1, 3'd5);
      wait_quiet("post_reset");
      measure_period(5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
